// File: rtl/layer_desc_fetcher.sv
// Layer descriptor fetcher: reads one DESC_WORDS-word descriptor per layer from memory,
// unpacks it onto the uLD field bus and waits for the layer decoder before fetching the next.
module layer_desc_fetcher #(
    parameter int DESC_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        start_i,
    input  logic [31:0] desc_base_i,
    input  logic [5:0]  num_layers_i,
    output logic        busy_o,
    output logic        done_o,

    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_gnt_i,
    input  logic        rd_rvalid_i,
    input  logic [31:0] rd_rdata_i,

    output logic        uLD_en_o,
    output logic [5:0]  layer_id_o,
    output logic [1:0]  layer_type_o,
    output logic [6:0]  in_R_o,
    output logic [6:0]  in_C_o,
    output logic [10:0] in_D_o,
    output logic [10:0] out_K_o,
    output logic [1:0]  stride_o,
    output logic [1:0]  pad_T_o,
    output logic [1:0]  pad_B_o,
    output logic [1:0]  pad_L_o,
    output logic [1:0]  pad_R_o,
    output logic [31:0] base_ifmap_o,
    output logic [31:0] base_weight_o,
    output logic [31:0] base_bias_o,
    output logic [31:0] base_ofmap_o,
    output logic [3:0]  flags_o,
    output logic [7:0]  quant_scale_o,

    input  logic        layer_done_i,
    output logic [5:0]  layer_idx_o
);

    localparam int WCW = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(DESC_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        ISSUE,
        WAIT_LAYER,
        FINISH
    } state_t;

    state_t         state;
    logic [WCW-1:0] word_cnt;
    logic [5:0]     num_layers;
    logic           data_beat;

    assign data_beat = (state == WAIT_DATA) && rd_rvalid_i;

    // rd_addr_o doubles as the running descriptor pointer; it only advances on a grant,
    // so it stays put while a request is being held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            word_cnt    <= '0;
            num_layers  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rd_req_o    <= 1'b0;
            rd_addr_o   <= '0;
            uLD_en_o    <= 1'b0;
            layer_idx_o <= '0;
        end else begin
            uLD_en_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        rd_addr_o   <= desc_base_i & 32'hFFFF_FFFC;
                        num_layers  <= num_layers_i;
                        word_cnt    <= '0;
                        layer_idx_o <= '0;
                        busy_o      <= 1'b1;
                        if (num_layers_i == 6'd0) begin
                            state <= FINISH;
                        end else begin
                            state    <= REQ;
                            rd_req_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (rd_gnt_i) begin
                        rd_req_o  <= 1'b0;
                        rd_addr_o <= rd_addr_o + 32'd4;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (rd_rvalid_i) begin
                        if (word_cnt == LAST_WORD) begin
                            state    <= ISSUE;
                            uLD_en_o <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + WCW'(1);
                            state    <= REQ;
                            rd_req_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_LAYER;
                end
                WAIT_LAYER: begin
                    if (layer_done_i) begin
                        layer_idx_o <= layer_idx_o + 6'd1;
                        if ((layer_idx_o + 6'd1) == num_layers) begin
                            state  <= FINISH;
                            done_o <= 1'b1;
                        end else begin
                            word_cnt <= '0;
                            state    <= REQ;
                            rd_req_o <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    // An empty run arrives here with done_o low and spends one busy cycle first.
                    if (done_o) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Field registers only move on the read beat of their own word, so the bus is
    // stable from the ISSUE strobe until the next layer's words start arriving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_id_o    <= '0;
            layer_type_o  <= '0;
            in_R_o        <= '0;
            in_C_o        <= '0;
            in_D_o        <= '0;
            out_K_o       <= '0;
            stride_o      <= '0;
            pad_T_o       <= '0;
            pad_B_o       <= '0;
            pad_L_o       <= '0;
            pad_R_o       <= '0;
            base_ifmap_o  <= '0;
            base_weight_o <= '0;
            base_bias_o   <= '0;
            base_ofmap_o  <= '0;
            flags_o       <= '0;
            quant_scale_o <= '0;
        end else if (data_beat) begin
            case (word_cnt)
                WCW'(0): begin
                    layer_id_o   <= rd_rdata_i[5:0];
                    layer_type_o <= rd_rdata_i[7:6];
                    in_R_o       <= rd_rdata_i[14:8];
                    in_C_o       <= rd_rdata_i[21:15];
                    stride_o     <= rd_rdata_i[23:22];
                    pad_T_o      <= rd_rdata_i[25:24];
                    pad_B_o      <= rd_rdata_i[27:26];
                    pad_L_o      <= rd_rdata_i[29:28];
                    pad_R_o      <= rd_rdata_i[31:30];
                end
                WCW'(1): begin
                    in_D_o  <= rd_rdata_i[10:0];
                    out_K_o <= rd_rdata_i[21:11];
                    flags_o <= rd_rdata_i[25:22];
                end
                WCW'(2): quant_scale_o <= rd_rdata_i[7:0];
                WCW'(3): base_ifmap_o  <= rd_rdata_i;
                WCW'(4): base_weight_o <= rd_rdata_i;
                WCW'(5): base_bias_o   <= rd_rdata_i;
                WCW'(6): base_ofmap_o  <= rd_rdata_i;
                default: ;
            endcase
        end
    end

endmodule
